// File: rtl/if_id_queue.sv
// Fetch-to-decode queue: circular buffer of DEPTH {instr, pc, pc+4} entries with
// first-word-fall-through head outputs, decode stall back-pressure and flush.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module if_id_queue #(
    parameter int                     DEPTH       = 4,
    parameter int                     DATA_WIDTH  = `DATA_WIDTH,
    parameter int                     INSTR_WIDTH = `INSTR_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_f_i,
    output logic                           ready_f_o,
    input  logic [INSTR_WIDTH-1:0]         instr_f_i,
    input  logic [DATA_WIDTH-1:0]          pc_f_i,
    input  logic [DATA_WIDTH-1:0]          pc_plus_4_f_i,
    input  logic                           flush_d_i,
    input  logic                           ready_id_i,
    output logic                           valid_id_o,
    output logic [INSTR_WIDTH-1:0]         instr_id_o,
    output logic [DATA_WIDTH-1:0]          pc_id_o,
    output logic [DATA_WIDTH-1:0]          pc_plus_4_id_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0]  pc;
        logic [DATA_WIDTH-1:0]  pc_plus_4;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               enq;
    logic               deq;

    // Handshakes depend only on registered count, so flush/ready_id never reach ready_f_o.
    assign ready_f_o  = (count != CNT_W'(DEPTH));
    assign valid_id_o = (count != '0);
    assign count_o    = count;

    assign enq = valid_f_i && ready_f_o && !flush_d_i;
    assign deq = valid_id_o && ready_id_i && !flush_d_i;

    // NOTE: storage is deliberately left out of reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{instr: instr_f_i, pc: pc_f_i, pc_plus_4: pc_plus_4_f_i};
        end
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_d_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the DEPTH-1 -> 0 wrap.
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
    always_comb begin
        instr_id_o     = NOP_INSTR;
        pc_id_o        = '0;
        pc_plus_4_id_o = '0;
        if (valid_id_o) begin
            instr_id_o     = head.instr;
            pc_id_o        = head.pc;
            pc_plus_4_id_o = head.pc_plus_4;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4): fill/stall/drain,
// full-with-dequeue, steady-state wrap, flush and asynchronous reset.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_f_i;
    logic        ready_f_o;
    logic [31:0] instr_f_i;
    logic [31:0] pc_f_i;
    logic [31:0] pc_plus_4_f_i;
    logic        flush_d_i;
    logic        ready_id_i;
    logic        valid_id_o;
    logic [31:0] instr_id_o;
    logic [31:0] pc_id_o;
    logic [31:0] pc_plus_4_id_o;
    logic [2:0]  count_o;

    int passed = 0;
    int total  = 0;

    if_id_queue #(.DEPTH(4), .DATA_WIDTH(32), .INSTR_WIDTH(32), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_f_i      (valid_f_i),
        .ready_f_o      (ready_f_o),
        .instr_f_i      (instr_f_i),
        .pc_f_i         (pc_f_i),
        .pc_plus_4_f_i  (pc_plus_4_f_i),
        .flush_d_i      (flush_d_i),
        .ready_id_i     (ready_id_i),
        .valid_id_o     (valid_id_o),
        .instr_id_o     (instr_id_o),
        .pc_id_o        (pc_id_o),
        .pc_plus_4_id_o (pc_plus_4_id_o),
        .count_o        (count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        valid_f_i     = 1'b1;
        instr_f_i     = 32'h1000_0000 | pc;
        pc_f_i        = pc;
        pc_plus_4_f_i = pc + 32'd4;
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_count"}, 32'(count_o), 32'd0);
        check({tag, "_valid"}, 32'(valid_id_o), 32'd0);
        check({tag, "_ready"}, 32'(ready_f_o), 32'd1);
        check({tag, "_instr"}, instr_id_o, NOP);
        check({tag, "_pc"}, pc_id_o, 32'd0);
        check({tag, "_pc4"}, pc_plus_4_id_o, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid_f_i = 1'b0; instr_f_i = '0; pc_f_i = '0; pc_plus_4_f_i = '0;
        flush_d_i = 1'b0; ready_id_i = 1'b0;
        #3;
        check_empty("reset");
        #9 rst_n = 1'b1;

        // First entry after reset: no bypass, visible one cycle later.
        valid_f_i = 1'b1; instr_f_i = 32'h0050_0093; pc_f_i = 32'h0; pc_plus_4_f_i = 32'h4;
        #0;
        check("first_no_bypass", 32'(valid_id_o), 32'd0);
        tick();
        check("first_valid", 32'(valid_id_o), 32'd1);
        check("first_instr", instr_id_o, 32'h0050_0093);
        check("first_pc", pc_id_o, 32'h0);
        check("first_pc4", pc_plus_4_id_o, 32'h4);
        check("first_count", 32'(count_o), 32'd1);

        // Fill to full with decode stalled.
        offer(32'h4); tick();
        offer(32'h8); tick();
        offer(32'hC); tick();
        check("full_count", 32'(count_o), 32'd4);
        check("full_ready", 32'(ready_f_o), 32'd0);
        offer(32'h10); tick();
        check("held_count", 32'(count_o), 32'd4);
        check("stall_head_pc", pc_id_o, 32'h0);
        check("stall_head_instr", instr_id_o, 32'h0050_0093);

        // Full with dequeue: enqueue refused this cycle, accepted the next.
        ready_id_i = 1'b1; tick();
        check("full_deq_count", 32'(count_o), 32'd3);
        check("full_deq_head", pc_id_o, 32'h4);
        tick();
        check("after_full_count", 32'(count_o), 32'd3);
        check("after_full_head", pc_id_o, 32'h8);
        valid_f_i = 1'b0; tick();
        check("drain_head_c", pc_id_o, 32'hC);
        check("drain_count_2", 32'(count_o), 32'd2);
        tick();
        check("drain_head_10", pc_id_o, 32'h10);
        check("drain_pc4_14", pc_plus_4_id_o, 32'h14);
        check("drain_instr_10", instr_id_o, 32'h1000_0010);
        tick();
        check_empty("drained");
        tick();
        check("empty_deq_count", 32'(count_o), 32'd0);

        // Steady state at count 2 with pointer wrap.
        ready_id_i = 1'b0;
        offer(32'h100); tick();
        offer(32'h104); tick();
        check("steady_pre_count", 32'(count_o), 32'd2);
        check("steady_pre_head", pc_id_o, 32'h100);
        ready_id_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(32'h108 + 32'(4 * i));
            tick();
            check($sformatf("steady_count_%0d", i), 32'(count_o), 32'd2);
            check($sformatf("steady_head_%0d", i), pc_id_o, 32'h104 + 32'(4 * i));
        end

        // Flush at count 3 with an offer in the same cycle.
        ready_id_i = 1'b0;
        offer(32'h200); tick();
        check("preflush_count", 32'(count_o), 32'd3);
        offer(32'h300); flush_d_i = 1'b1; tick();
        check_empty("flush");
        flush_d_i = 1'b0; valid_f_i = 1'b0; tick();
        check("postflush_count", 32'(count_o), 32'd0);
        offer(32'h400); tick();
        check("postflush_head", pc_id_o, 32'h400);

        // Asynchronous reset mid-cycle with count 2.
        offer(32'h404); tick();
        valid_f_i = 1'b0;
        check("prereset_count", 32'(count_o), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_empty("async_reset");
        #3 rst_n = 1'b1;
        offer(32'h500); tick();
        check("post_reset_head", pc_id_o, 32'h500);
        check("post_reset_count", 32'(count_o), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of fetch/decode entries; SHALL be a power of two, >= 2.
REQ-002 Parameter DATA_WIDTH, default `DATA_WIDTH (32), width of PC fields.
REQ-003 Parameter INSTR_WIDTH, default `INSTR_WIDTH (32), width of instruction field.
REQ-004 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction presented when no valid entry.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 valid_f_i  input  1  fetch offers an entry this cycle.
REQ-008 ready_f_o  output  1  queue accepts an entry this cycle.
REQ-009 instr_f_i  input  INSTR_WIDTH  fetched instruction.
REQ-010 pc_f_i  input  DATA_WIDTH  PC of fetched instruction.
REQ-011 pc_plus_4_f_i  input  DATA_WIDTH  PC+4 of fetched instruction.
REQ-012 flush_d_i  input  1  discard all queued entries (branch/jump redirect).
REQ-013 ready_id_i  input  1  decode consumes head entry this cycle (deasserted = decode stall).
REQ-014 valid_id_o  output  1  head entry valid.
REQ-015 instr_id_o  output  INSTR_WIDTH  head instruction, NOP_INSTR when empty.
REQ-016 pc_id_o  output  DATA_WIDTH  head PC, 0 when empty.
REQ-017 pc_plus_4_id_o  output  DATA_WIDTH  head PC+4, 0 when empty.
REQ-018 count_o  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.

Function
REQ-019 Storage SHALL be a circular buffer of DEPTH entries {instr, pc, pc_plus_4} with read/write pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0.
REQ-020 ready_f_o SHALL equal (count_o != DEPTH), registered-state only; no combinational path from ready_id_i or flush_d_i.
REQ-021 Enqueue occurs when valid_f_i && ready_f_o && !flush_d_i: entry written at write pointer, write pointer +1.
REQ-022 Dequeue occurs when valid_id_o && ready_id_i && !flush_d_i: read pointer +1.
REQ-023 valid_id_o SHALL equal (count_o != 0); outputs are first-word-fall-through from the head entry, no bypass: an entry enqueued into an empty queue is visible on valid_id_o the cycle after acceptance (latency 1).
REQ-024 Simultaneous enqueue and dequeue SHALL leave count_o unchanged; permitted at any count 1..DEPTH-1.
REQ-025 When full, enqueue is refused even if a dequeue occurs the same cycle; count decrements to DEPTH-1.
REQ-026 ready_id_i while empty SHALL have no effect; valid_f_i while full SHALL have no effect (entry held by fetch).
REQ-027 flush_d_i SHALL, at the next edge, set count_o to 0 and both pointers to 0; any enqueue or dequeue in the flush cycle is discarded.
REQ-028 While count_o == 0, instr_id_o = NOP_INSTR, pc_id_o = 0, pc_plus_4_id_o = 0, regardless of stale storage.
REQ-029 Head outputs SHALL hold stable while valid_id_o && !ready_id_i (decode stall).
REQ-030 count_o SHALL never exceed DEPTH nor underflow below 0.

Reset
REQ-031 On rst_n low, asynchronously: count_o=0, pointers=0, valid_id_o=0, ready_f_o=1, instr_id_o=NOP_INSTR, pc_id_o=0, pc_plus_4_id_o=0.
REQ-032 Storage contents need not be reset; reset mid-operation discards all entries identically to REQ-031.
REQ-033 First enqueue accepted on first rising edge after rst_n deasserts.

Verification
REQ-034 Reset then enqueue {0x00500093, pc 0x0, 0x4} with ready_id_i=0 -> next cycle valid_id_o=1, instr_id_o=0x00500093, pc_id_o=0x0, count_o=1.
REQ-035 DEPTH=4, ready_id_i=0, offer 5 entries pc 0x0..0x10 -> count_o=4, ready_f_o=0 after 4th, 5th held; raise ready_id_i -> heads pc 0x0,0x4,0x8,0xC in order, then 0x10 accepted.
REQ-036 Count=2, valid_f_i=1 and ready_id_i=1 for 10 cycles -> count_o stays 2, pointers wrap, pc order preserved.
REQ-037 Count=3, assert flush_d_i with valid_f_i=1 -> next cycle count_o=0, valid_id_o=0, instr_id_o=0x00000013, offered entry discarded.
REQ-038 Full queue, ready_id_i=1, valid_f_i=1 -> count_o=3, no enqueue that cycle; next cycle enqueue accepted.
REQ-039 Assert rst_n=0 mid-cycle with count_o=2 -> outputs immediately take REQ-031 values without clock edge.
